// File: rtl/wb_timing_master.sv
// Wishbone classic single-transfer initiator that measures slave ack latency, with a timeout bound.
// One bus cycle per command, response held until rsp_ready; next command accepted one cycle later.
module wb_timing_master #(
   parameter int LAT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [3:0]       cmd_sel,
   input  logic [31:0]      cmd_adr,
   input  logic [31:0]      cmd_dat,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic [31:0]      wbm_dat_i,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_dat,
   output logic             rsp_timeout,
   output logic [LAT_W-1:0] rsp_latency
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } cmd_t;

   localparam logic [LAT_W-1:0] TO_L    = LAT_W'(TIMEOUT);
   localparam logic [LAT_W-1:0] CNT_MAX = '1;
   localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

   state_t           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             cyc_q, cyc_d;
   logic             stb_q, stb_d;
   cmd_t             cmd_q, cmd_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_dat_q, rsp_dat_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic [LAT_W-1:0] rsp_latency_q, rsp_latency_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cmd_ready_d   = cmd_ready_q;
      cyc_d         = cyc_q;
      stb_d         = stb_q;
      cmd_d         = cmd_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_dat_d     = rsp_dat_q;
      rsp_timeout_d = rsp_timeout_q;
      rsp_latency_d = rsp_latency_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               cmd_d.we      = cmd_we;
               cmd_d.sel     = cmd_sel;
               cmd_d.adr     = cmd_adr;
               cmd_d.dat     = cmd_dat;
               cyc_d         = 1'b1;
               stb_d         = 1'b1;
               cnt_d         = CNT_ONE;
               rsp_dat_d     = '0;
               rsp_timeout_d = 1'b0;
               rsp_latency_d = '0;
               cmd_ready_d   = 1'b0;
               state_d       = BUS;
            end
         end
         BUS: begin
            // An ack in the timeout cycle still counts as a completed transfer.
            if (wbm_ack_i) begin
               rsp_latency_d = cnt_q;
               rsp_dat_d     = cmd_q.we ? 32'h0 : wbm_dat_i;
               rsp_timeout_d = 1'b0;
               cyc_d         = 1'b0;
               stb_d         = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_L)) begin
               rsp_latency_d = TO_L;
               rsp_dat_d     = '0;
               rsp_timeout_d = 1'b1;
               cyc_d         = 1'b0;
               stb_d         = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cmd_ready_q   <= 1'b1;
         cyc_q         <= 1'b0;
         stb_q         <= 1'b0;
         cmd_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_dat_q     <= '0;
         rsp_timeout_q <= 1'b0;
         rsp_latency_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         cyc_q         <= cyc_d;
         stb_q         <= stb_d;
         cmd_q         <= cmd_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_dat_q     <= rsp_dat_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_latency_q <= rsp_latency_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = stb_q;
   assign wbm_we_o    = cmd_q.we;
   assign wbm_sel_o   = cmd_q.sel;
   assign wbm_adr_o   = cmd_q.adr;
   assign wbm_dat_o   = cmd_q.dat;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_dat     = rsp_dat_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_latency = rsp_latency_q;

endmodule

// File: tb/tb_wb_timing_master.sv
// Bench for wb_timing_master: programmable-latency slave plus a transfer-level reference model.
module tb_wb_timing_master;
   localparam int LAT_W   = 16;
   localparam int TIMEOUT = 1000;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] rdat;
      int          ack_at;   // stb cycle index in which the slave acks; 0 = never
   } xfer_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_we = 1'b0;
   logic [3:0]       cmd_sel = '0;
   logic [31:0]      cmd_adr = '0;
   logic [31:0]      cmd_dat = '0;
   logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]       wbm_sel_o;
   logic [31:0]      wbm_adr_o, wbm_dat_o;
   logic             wbm_ack_i;
   logic [31:0]      wbm_dat_i;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [31:0]      rsp_dat;
   logic             rsp_timeout;
   logic [LAT_W-1:0] rsp_latency;

   int          vecs = 0;
   int          errs = 0;
   int          s_ack_at = 0;
   logic [31:0] s_rdat = '0;
   logic        stray_ack = 1'b0;
   int          stb_idx;

   wb_timing_master #(.LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_timeout(rsp_timeout), .rsp_latency(rsp_latency)
   );

   always #5 clk = ~clk;

   // stb_idx = number of completed stb cycles before the current one
   always @(posedge clk or posedge rst) begin
      if (rst) stb_idx <= 0;
      else     stb_idx <= wbm_stb_o ? stb_idx + 1 : 0;
   end

   assign wbm_ack_i = (wbm_stb_o && (s_ack_at != 0) && (stb_idx + 1 == s_ack_at)) || stray_ack;
   assign wbm_dat_i = s_rdat;

   function automatic void model(input xfer_t x, output int lat, output logic to,
                                 output logic [31:0] d);
      if (x.ack_at != 0 && (TIMEOUT == 0 || x.ack_at <= TIMEOUT)) begin
         lat = x.ack_at;
         to  = 1'b0;
         d   = x.we ? 32'h0 : x.rdat;
      end else begin
         lat = TIMEOUT;
         to  = 1'b1;
         d   = 32'h0;
      end
   endfunction

   function automatic xfer_t rand_xfer(input int ack_at);
      xfer_t x;
      x.we     = ($urandom_range(0, 1) == 1);
      x.sel    = 4'($urandom_range(0, 15));
      x.adr    = $urandom;
      x.dat    = $urandom;
      x.rdat   = $urandom;
      x.ack_at = ack_at;
      return x;
   endfunction

   task automatic drive_cmd(input xfer_t x);
      cmd_we    = x.we;
      cmd_sel   = x.sel;
      cmd_adr   = x.adr;
      cmd_dat   = x.dat;
      cmd_valid = 1'b1;
   endtask

   // Called just after a negedge; returns at the negedge of the first stb cycle.
   task automatic issue(input xfer_t x, input bit keep);
      int n = 0;
      stray_ack = 1'b0;
      s_ack_at  = x.ack_at;
      s_rdat    = x.rdat;
      drive_cmd(x);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (cmd_ready !== 1'b1) begin
         errs++;
         $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic finish_xfer(input xfer_t x, input int hold);
      int               lat;
      logic             to;
      logic [31:0]      d;
      int               stb_cnt = 0;
      int               bad = 0;
      int               hbad = 0;
      int               n = 0;
      logic [31:0]      c_dat;
      logic [LAT_W-1:0] c_lat;
      logic             c_to;
      model(x, lat, to, d);
      while (!rsp_valid && n < 3000) begin
         if (wbm_stb_o) begin
            stb_cnt++;
            if (wbm_cyc_o !== 1'b1 || wbm_we_o !== x.we || wbm_sel_o !== x.sel ||
                wbm_adr_o !== x.adr || wbm_dat_o !== x.dat) bad++;
         end
         @(negedge clk);
         n++;
      end
      vecs++;
      if (rsp_valid !== 1'b1) begin
         errs++;
         $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
      end
      vecs++;
      if (stb_cnt != lat) begin
         errs++;
         $display("FAIL stb_cycles: got %0d required %0d", stb_cnt, lat);
      end
      vecs++;
      if (bad != 0) begin
         errs++;
         $display("FAIL bus_stable: %0d stb cycles with wrong cyc/we/sel/adr/dat", bad);
      end
      vecs++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
         errs++;
         $display("FAIL bus_drop: cyc=%b stb=%b required 0 0", wbm_cyc_o, wbm_stb_o);
      end
      vecs++;
      if (rsp_timeout !== to) begin
         errs++;
         $display("FAIL rsp_timeout: got %b required %b", rsp_timeout, to);
      end
      vecs++;
      if (rsp_latency !== LAT_W'(lat)) begin
         errs++;
         $display("FAIL rsp_latency: got %0d required %0d", rsp_latency, lat);
      end
      vecs++;
      if (rsp_dat !== d) begin
         errs++;
         $display("FAIL rsp_dat: got %h required %h", rsp_dat, d);
      end
      c_dat = rsp_dat;
      c_lat = rsp_latency;
      c_to  = rsp_timeout;
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         stray_ack = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_dat !== c_dat ||
             rsp_latency !== c_lat || rsp_timeout !== c_to || wbm_cyc_o !== 1'b0) hbad++;
      end
      vecs++;
      if (hbad != 0) begin
         errs++;
         $display("FAIL rsp_hold: %0d of %0d held cycles unstable", hbad, hold);
      end
      stray_ack = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      vecs++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errs++;
         $display("FAIL release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vecs++;
      if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 ||
          wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 ||
          rsp_valid !== 1'b0 || rsp_dat !== 32'h0 || rsp_timeout !== 1'b0 ||
          rsp_latency !== '0) begin
         errs++;
         $display("FAIL reset_state: cmd_ready=%b cyc=%b stb=%b rsp_valid=%b lat=%0d required 1 0 0 0 0",
                  cmd_ready, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_latency);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed;
      xfer_t x;
      x = '{we: 1'b1, sel: 4'hF, adr: 32'h3000_0000, dat: 32'hBEEF_0000, rdat: 32'h5555_AAAA, ack_at: 2};
      issue(x, 1'b0);
      finish_xfer(x, 0);
      x = '{we: 1'b0, sel: 4'hF, adr: 32'h3000_0004, dat: 32'h0, rdat: 32'h1234_5678, ack_at: 1};
      issue(x, 1'b0);
      finish_xfer(x, 1);
   endtask

   task automatic test_timeout;
      xfer_t x;
      x = '{we: 1'b0, sel: 4'h3, adr: 32'h3000_0010, dat: 32'h0, rdat: 32'hCAFE_F00D, ack_at: 0};
      issue(x, 1'b0);
      finish_xfer(x, 2);
      x = '{we: 1'b0, sel: 4'hF, adr: 32'h3000_0020, dat: 32'h0, rdat: 32'h0BAD_BEEF, ack_at: TIMEOUT};
      issue(x, 1'b0);
      finish_xfer(x, 5);
      x = '{we: 1'b1, sel: 4'h1, adr: 32'h3000_0030, dat: 32'h1, rdat: 32'h7777_7777, ack_at: TIMEOUT + 1};
      issue(x, 1'b0);
      finish_xfer(x, 0);
   endtask

   task automatic test_reset_mid;
      xfer_t x;
      x = '{we: 1'b1, sel: 4'hF, adr: 32'h3000_0040, dat: 32'h1111_2222, rdat: 32'h0, ack_at: 0};
      issue(x, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      vecs++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_mid: cyc=%b stb=%b rsp_valid=%b cmd_ready=%b required 0 0 0 1",
                  wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready);
      end
      #1;
      rst = 1'b0;
      @(negedge clk);
      x = '{we: 1'b0, sel: 4'hF, adr: 32'h3000_0044, dat: 32'h0, rdat: 32'hA5A5_A5A5, ack_at: 4};
      issue(x, 1'b0);
      finish_xfer(x, 1);
   endtask

   task automatic test_stray_idle;
      int bad = 0;
      cmd_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         stray_ack = ($urandom_range(0, 1) == 1) || (i == 0);
         @(negedge clk);
         if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      stray_ack = 1'b0;
      vecs++;
      if (bad != 0) begin
         errs++;
         $display("FAIL stray_idle: %0d cycles with rsp_valid/cyc set or cmd_ready low", bad);
      end
   endtask

   task automatic test_back_to_back;
      xfer_t a, b;
      a = rand_xfer(3);
      b = rand_xfer(2);
      issue(a, 1'b1);
      drive_cmd(b);
      finish_xfer(a, 2);
      vecs++;
      if (wbm_stb_o !== 1'b0) begin
         errs++;
         $display("FAIL b2b_gap: stb=%b in cmd_ready cycle, required 0", wbm_stb_o);
      end
      s_ack_at = b.ack_at;
      s_rdat   = b.rdat;
      @(negedge clk);
      vecs++;
      if (wbm_stb_o !== 1'b1 || cmd_ready !== 1'b0 || wbm_adr_o !== b.adr) begin
         errs++;
         $display("FAIL b2b_start: stb=%b cmd_ready=%b adr=%h required 1 0 %h",
                  wbm_stb_o, cmd_ready, wbm_adr_o, b.adr);
      end
      cmd_valid = 1'b0;
      finish_xfer(b, 0);
   endtask

   task automatic test_random;
      xfer_t x;
      for (int i = 0; i < 24; i++) begin
         x = rand_xfer($urandom_range(1, 12));
         issue(x, 1'b0);
         finish_xfer(x, $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stray_idle();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_timing_master.md
Name: wb_timing_master

Overview:
- Wishbone classic single-transfer initiator that drives the user-area Wishbone slave port from a local command/response interface.
- Each command issues exactly one read or write bus cycle and measures the slave's acknowledge latency in clock cycles.
- It aborts with a timeout flag if no acknowledge arrives within a programmed bound.
- Used on-chip as the bus-timing characterisation engine for user-area responders.

Parameters:
- LAT_W, 16, width of the latency counter and of rsp_latency.
- TIMEOUT, 1000, maximum cycles stb may stay asserted without ack; 0 disables timeout. Must be < 2^LAT_W.

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge
- wb_rst_i  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block accepts a command this cycle
- cmd_we  input  1  1 = write, 0 = read
- cmd_sel  input  4  byte selects
- cmd_adr  input  32  bus address
- cmd_dat  input  32  write data
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_sel_o  output  4  Wishbone byte selects
- wbm_adr_o  output  32  Wishbone address
- wbm_dat_o  output  32  Wishbone write data
- wbm_ack_i  input  1  Wishbone acknowledge
- wbm_dat_i  input  32  Wishbone read data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_dat  output  32  read data; 0 for writes and timeouts
- rsp_timeout  output  1  transfer aborted by timeout
- rsp_latency  output  LAT_W  cycles from first stb cycle to ack, inclusive

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release) values: all outputs 0 except cmd_ready=1; state=IDLE; latency counter=0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch we/sel/adr/dat onto the wbm_* outputs and set cyc=stb=1 on the next edge.
  - Clear the counter to 1 and the response fields to 0; cmd_ready=0; go to BUS.
- BUS:
  - cyc/stb and all wbm_* outputs are held stable.
  - The counter holds the index of the current stb cycle (first stb cycle = 1).
  - wbm_ack_i sampled high: rsp_latency<=counter; rsp_dat<=wbm_dat_i if read, else 0; rsp_timeout<=0; cyc=stb=0 next edge; rsp_valid<=1; go to RESP.
  - No ack and TIMEOUT!=0 and counter==TIMEOUT: rsp_timeout<=1; rsp_dat<=0; rsp_latency<=TIMEOUT; drop cyc/stb; rsp_valid<=1; go to RESP.
  - Otherwise the counter increments.
  - Ack and timeout in the same cycle: ack wins and rsp_timeout=0.
  - TIMEOUT=0: wait for ack indefinitely; the counter saturates at 2^LAT_W-1.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid<=0, cmd_ready<=1, go to IDLE.
  - The next command cannot be accepted in the same cycle as rsp_ready, so minimum command spacing is (latency + 2) cycles.
- Stray wbm_ack_i in IDLE or RESP is ignored; no state or output change.
- wbm_dat_o, wbm_adr_o, wbm_sel_o and wbm_we_o retain their last values after the cycle ends; they are only meaningful while cyc=1.
- Reset asserted mid-transfer: cyc/stb drop immediately (async) and any pending response is discarded.
- Widths: the counter is LAT_W unsigned; no other arithmetic.

Test Plan:
- Registered-ack slave (ack one cycle after stb), write adr 0x3000_0000, dat 0xBEEF0000, sel 0xF -> wbm_we_o=1, wbm_dat_o=0xBEEF0000 for 2 stb cycles; rsp_latency=2, rsp_timeout=0, rsp_dat=0; cyc drops the cycle after ack.
- Combinational-ack slave, read returning 0x12345678 -> rsp_latency=1, rsp_dat=0x12345678, stb high exactly 1 cycle.
- Slave never acks, TIMEOUT=1000 -> stb high exactly 1000 cycles, then rsp_timeout=1, rsp_latency=1000, rsp_dat=0.
- Ack asserted in stb cycle 1000 (TIMEOUT=1000) -> rsp_timeout=0, rsp_latency=1000; rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout.
- Reset pulsed during BUS at stb cycle 3 -> cyc/stb/rsp_valid=0 before the next edge, cmd_ready=1. A following read of 0xA5A5A5A5 with ack after 4 cycles -> rsp_latency=4.
- Stray ack pulses in IDLE and RESP, plus back-to-back commands with cmd_valid held high -> no spurious response; second command's stb rises 1 cycle after cmd_ready reasserts.
